counter_cmd_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the 8-bit loadable counter and drives its `data_in`, `ld` and `inc` inputs. It accepts one command at a time over a valid/ready handshake and expands it into a one-cycle load and/or a burst of N increment cycles. It also keeps a shadow model of the counter value (`exp_q`) so that downstream logic and benches can check the counter without re-deriving its state.

---
 rtl/counter_cmd_ctrl_if.sv | 31 +++
 rtl/counter_cmd_ctrl.sv | 137 +++++++++++++
 tb/tb_counter_cmd_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/counter_cmd_ctrl_if.sv
// counter_cmd_ctrl_if
// Groups the command handshake, the abort input, the counter drive outputs and
// the status outputs of counter_cmd_ctrl.
//   master : command source (drives cmd_*, abort; observes everything else)
//   slave  : the sequencer itself
interface counter_cmd_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] cmd_len;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic             ld;
  logic             inc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] exp_q;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_len, abort,
    input  cmd_ready, data_in, ld, inc, busy, done, exp_q
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_len, abort,
    output cmd_ready, data_in, ld, inc, busy, done, exp_q
  );
endinterface

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl
// Command sequencer in front of an 8-bit loadable counter. One command is
// accepted at a time and expanded into a one-cycle load and/or a burst of N
// increments. A shadow copy of the counter value is kept on exp_q.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : counter_cmd_if slave (cmd handshake, abort, data_in/ld/inc drive,
//          busy/done status, exp_q shadow value)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | ready for a command
// LOAD   | ld asserted for one cycle
// INC    | inc asserted, remaining count decrements
// DONE   | one-cycle completion pulse
module counter_cmd_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  counter_cmd_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_INC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_INC    = 2'b10;
  localparam logic [1:0] OP_LDINC  = 2'b11;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_data_in;
  logic [WIDTH-1:0] r_exp_q;
  logic             r_ld;
  logic             r_inc;
  logic             r_done;
  logic             w_accept;
  logic             w_ld_nxt;
  logic             w_inc_nxt;
  logic             w_done_nxt;

  // abort coincident with an accept is deliberately not looked at here
  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);

  // state register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_NOP;
      r_ld    <= 1'b0;
      r_inc   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ld    <= w_ld_nxt;
      r_inc   <= w_inc_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) r_op <= bus.cmd_op;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = bus.cmd_len;
          case (bus.cmd_op)
            OP_LOAD, OP_LDINC: w_state_nxt = S_LOAD;
            OP_INC:            w_state_nxt = (bus.cmd_len != '0) ? S_INC : S_DONE;
            default:           w_state_nxt = S_DONE;
          endcase
        end
      end
      S_LOAD: begin
        if (bus.abort)                             w_state_nxt = S_IDLE;
        else if (r_op == OP_LDINC && r_cnt != '0)  w_state_nxt = S_INC;
        else                                       w_state_nxt = S_DONE;
      end
      S_INC: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          // count is always >0 on entry, so the burst is exactly N cycles
          w_cnt_nxt = r_cnt - WIDTH'(1);
          if (r_cnt == WIDTH'(1)) w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they are registered yet
  // line up exactly with the state they belong to
  always_comb begin
    w_ld_nxt   = (w_state_nxt == S_LOAD);
    w_inc_nxt  = (w_state_nxt == S_INC);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // load value and shadow counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_in <= '0;
      r_exp_q   <= '0;
    end else begin
      if (w_accept && bus.cmd_op[0]) r_data_in <= bus.cmd_data;
      // mirrors the counter: ld has priority, inc wraps naturally
      if (r_ld)       r_exp_q <= r_data_in;
      else if (r_inc) r_exp_q <= r_exp_q + WIDTH'(1);
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.data_in   = r_data_in;
  assign bus.ld        = r_ld;
  assign bus.inc       = r_inc;
  assign bus.done      = r_done;
  assign bus.exp_q     = r_exp_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
module tb_counter_cmd_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  logic [7:0] m_q   = 8'h00;
  logic [7:0] m_din = 8'h00;

  counter_cmd_if #(.WIDTH(8)) bus ();

  counter_cmd_ctrl #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // a command is accepted at the edge following a negedge that sees valid&&ready
  always @(negedge clk)
    if (rst && bus.cmd_valid && bus.cmd_ready) n_acc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Issues one command from idle and watches it to completion.
  // abort_at = k raises abort during the k-th inc cycle (0 = never).
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] len, input int abort_at);
    int n_ld = 0, n_inc = 0, n_done = 0, n_busy = 0, inc_e;
    logic pld = 1'b0, pinc = 1'b0, last_done = 1'b0;
    logic [7:0] rq, din_e;
    bit fin = 0, aborted;
    rq    = m_q;
    din_e = op[0] ? d : m_din;
    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = d; bus.cmd_len = len;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_data = 8'($urandom); bus.cmd_len = 8'($urandom);
    for (int c = 0; c < 600 && !fin; c++) begin
      rq = pld ? din_e : (pinc ? rq + 8'd1 : rq);
      chk("exp_q_step", bus.exp_q, rq);
      chk("data_in_step", bus.data_in, din_e);
      chk("ld_inc_exclusive", bus.ld & bus.inc, 0);
      if (!bus.busy) fin = 1;
      else begin
        n_busy++;
        n_ld += int'(bus.ld); n_inc += int'(bus.inc); n_done += int'(bus.done);
        last_done = bus.done;
        if (bus.inc && n_inc == abort_at) bus.abort = 1'b1;
      end
      pld = bus.ld; pinc = bus.inc;
      if (!fin) begin @(posedge clk); #2; bus.abort = 1'b0; end
    end
    if (!fin) chk("cmd_timeout", 0, 1);
    aborted = (abort_at != 0) && op[1] && (abort_at <= int'(len));
    inc_e   = !op[1] ? 0 : (aborted ? abort_at : int'(len));
    chk("ld_cycles", n_ld, int'(op[0]));
    chk("inc_cycles", n_inc, inc_e);
    chk("done_pulses", n_done, aborted ? 0 : 1);
    chk("done_last_cycle", last_done, !aborted);
    chk("busy_cycles", n_busy, int'(op[0]) + inc_e + (aborted ? 0 : 1));
    chk("ready_after_cmd", bus.cmd_ready, 1);
    if (op[0]) m_q = d;
    m_q   = m_q + 8'(inc_e);
    m_din = din_e;
    chk("exp_q_final", bus.exp_q, m_q);
    chk("data_in_final", bus.data_in, m_din);
  endtask

  initial begin
    int base, waited;
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = 8'h00;
    bus.cmd_len = 8'h00; bus.abort = 1'b0;
    #1;
    chk("rst_ld", bus.ld, 0);
    chk("rst_inc", bus.inc, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_exp_q", bus.exp_q, 0);
    chk("rst_data_in", bus.data_in, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;

    // load something, then reset asynchronously in the middle of an INC burst
    run_cmd(2'b01, 8'h5A, 8'd0, 0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_len = 8'd200;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_ld", bus.ld, 0);
    chk("arst_inc", bus.inc, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_exp_q", bus.exp_q, 0);
    chk("arst_data_in", bus.data_in, 0);
    chk("arst_busy", bus.busy, 0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    chk("arst_no_accept", bus.busy, 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_ready", bus.cmd_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    m_q = 8'h00; m_din = 8'h00;

    // long burst from 0
    run_cmd(2'b10, 8'hAA, 8'd200, 0);
    chk("inc200_value", bus.exp_q, 8'hC8);

    // load then load+inc through the wrap
    run_cmd(2'b01, 8'hF0, 8'd0, 0);
    chk("load_f0", bus.exp_q, 8'hF0);
    run_cmd(2'b11, 8'hFF, 8'd1, 0);
    chk("wrap_to_0", bus.exp_q, 8'h00);

    // zero-length and NOP
    run_cmd(2'b10, 8'h77, 8'd0, 0);
    run_cmd(2'b00, 8'h66, 8'd5, 0);
    chk("nop_keeps_din", bus.data_in, 8'hFF);

    // abort on the 4th increment
    run_cmd(2'b11, 8'h10, 8'd10, 4);
    chk("abort_value", bus.exp_q, 8'h14);
    @(posedge clk); #2;
    chk("abort_stays_idle", bus.busy, 0);

    // back-to-back with valid held high
    base = n_acc;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_data = 8'h33; bus.cmd_len = 8'd0;
    @(posedge clk); #2;
    chk("b2b_first_accept", n_acc, base + 1);
    bus.cmd_op = 2'b10; bus.cmd_data = 8'h99; bus.cmd_len = 8'd3;
    waited = 0;
    while (n_acc == base + 1 && waited < 20) begin
      @(posedge clk); #2; waited++;
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_second_edge", waited, 3);
    waited = 0;
    while (bus.busy && waited < 50) begin @(posedge clk); #2; waited++; end
    chk("b2b_completes", bus.busy, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("b2b_accept_count", n_acc, base + 2);
    chk("b2b_exp_q", bus.exp_q, 8'h36);
    chk("b2b_data_in", bus.data_in, 8'h33);
    m_q = 8'h36; m_din = 8'h33;

    // random commands
    for (int i = 0; i < 30; i++) begin
      logic [1:0] op;
      logic [7:0] d, len;
      int ab;
      op  = 2'($urandom);
      d   = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(len) + 1) : 0;
      run_cmd(op, d, len, ab);
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #2; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
